// File: rtl/pc_npc_unit_pkg.sv
// Shared encodings for the SPARC PC/nPC unit: transfer kinds, FSM states, target select.
package pc_npc_unit_pkg;

    localparam logic [2:0] PC_OP_SEQ  = 3'b000;
    localparam logic [2:0] PC_OP_BICC = 3'b001;
    localparam logic [2:0] PC_OP_CALL = 3'b010;
    localparam logic [2:0] PC_OP_JMPL = 3'b011;
    localparam logic [2:0] PC_OP_TRAP = 3'b100;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        TGT_INC  = 2'd0,
        TGT_DISP = 2'd1,
        TGT_PASS = 2'd2
    } tgt_sel_e;

endpackage

// File: rtl/pc_target_adder.sv
// Next-nPC target: base+4, pc+disp, or a passthrough address (jmp_addr).
module pc_target_adder
    import pc_npc_unit_pkg::*;
(
    input  tgt_sel_e    sel,
    input  logic [31:0] base,
    input  logic [31:0] pc,
    input  logic [31:0] disp,
    input  logic [31:0] pass,
    output logic [31:0] target
);

    always_comb begin
        target = base + WORD_BYTES;
        unique case (sel)
            TGT_INC:  target = base + WORD_BYTES;
            TGT_DISP: target = pc + disp;
            TGT_PASS: target = pass;
            default:  target = base + WORD_BYTES;
        endcase
    end

endmodule

// File: rtl/pc_npc_unit.sv
// SPARC V8 PC/nPC pair with delayed-branch and annul handling.
// Optional target alignment flag enabled by defining PC_ALIGN_CHECK_EN.
module pc_npc_unit
    import pc_npc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [2:0]        op,
    input  logic              taken,
    input  logic              br_always,
    input  logic              annul,
    input  logic [ADDR_W-1:0] disp,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic [ADDR_W-1:0] tbr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              slot_valid,
    output logic              misalign
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [ADDR_W-1:0] inc_base;
    logic [ADDR_W-1:0] target;
    tgt_sel_e          sel;
    logic              upd;

    pc_target_adder u_adder (
        .sel    (sel),
        .base   (inc_base),
        .pc     (pc_q),
        .disp   (disp),
        .pass   (jmp_addr),
        .target (target)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sel      = TGT_INC;
        inc_base = npc_q;
        upd      = 1'b0;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_SQUASH: begin
                // The annulled instruction contributes nothing, not even a trap.
                if (advance) begin
                    upd     = 1'b1;
                    pc_d    = npc_q;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    upd     = 1'b1;
                    pc_d    = npc_q;
                    state_d = ST_RUN;
                    case (op)
                        PC_OP_BICC: begin
                            if (taken) sel = TGT_DISP;
                            if (annul && (!taken || br_always)) state_d = ST_SQUASH;
                        end
                        PC_OP_CALL: sel = TGT_DISP;
                        PC_OP_JMPL: sel = TGT_PASS;
                        PC_OP_TRAP: begin
                            pc_d     = tbr;
                            inc_base = tbr;
                        end
                        default: sel = TGT_INC;
                    endcase
                end
            end
            default: state_d = ST_BOOT;
        endcase
        npc_d = upd ? target : npc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + WORD_BYTES;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (upd) begin
            mis_q <= (target[1:0] != 2'b00);
        end
    end

    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign pc         = pc_q;
    assign npc        = npc_q;
    assign slot_valid = (state_q == ST_RUN);

endmodule

// File: tb/tb_pc_npc_unit.sv
// Self-checking bench for pc_npc_unit: directed scenarios plus random ops vs. a behavioural model.
module tb_pc_npc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BICC = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_JMPL = 3'd3;
    localparam logic [2:0] OP_TRAP = 3'd4;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        advance = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        taken = 1'b0;
    logic        br_always = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] disp = 32'd0;
    logic [31:0] jmp_addr = 32'd0;
    logic [31:0] tbr = 32'd0;
    logic [31:0] pc, npc;
    logic        slot_valid, misalign;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc, m_npc;
    bit          m_boot, m_squash, m_mis;

    pc_npc_unit #(
        .RESET_PC (RST_PC),
        .ADDR_W   (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .op         (op),
        .taken      (taken),
        .br_always  (br_always),
        .annul      (annul),
        .disp       (disp),
        .jmp_addr   (jmp_addr),
        .tbr        (tbr),
        .pc         (pc),
        .npc        (npc),
        .slot_valid (slot_valid),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_npc    = RST_PC + 32'd4;
        m_boot   = 1'b1;
        m_squash = 1'b0;
        m_mis    = 1'b0;
    endtask

    // Architectural rules: delayed transfer goes through nPC; annul discards the delay slot.
    task automatic model_edge();
        logic [31:0] p, n, np, nn;
        bit          sq;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (advance) begin
            p  = m_pc;
            n  = m_npc;
            np = n;
            nn = n + 32'd4;
            sq = 1'b0;
            if (!m_squash) begin
                if (op == OP_BICC) begin
                    if (taken) nn = p + disp;
                    sq = annul && (!taken || (br_always && taken));
                end else if (op == OP_CALL) begin
                    nn = p + disp;
                end else if (op == OP_JMPL) begin
                    nn = jmp_addr;
                end else if (op == OP_TRAP) begin
                    np = tbr;
                    nn = tbr + 32'd4;
                end
            end
            m_pc     = np;
            m_npc    = nn;
            m_squash = sq;
            m_mis    = ALIGN_EN && (nn[1:0] != 2'b00);
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_pc"}, pc, m_pc);
        check_val({tag, "_npc"}, npc, m_npc);
        check_val({tag, "_valid"}, {31'd0, slot_valid}, {31'd0, !m_boot && !m_squash});
        check_val({tag, "_mis"}, {31'd0, misalign}, {31'd0, m_mis});
    endtask

    task automatic step(input string tag, input logic adv, input logic [2:0] o, input logic tk,
                        input logic ba, input logic an, input logic [31:0] d,
                        input logic [31:0] j, input logic [31:0] t);
        advance   = adv;
        op        = o;
        taken     = tk;
        br_always = ba;
        annul     = an;
        disp      = d;
        jmp_addr  = j;
        tbr       = t;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic seq(input string tag);
        step(tag, 1'b1, OP_SEQ, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic trap_to(input string tag, input logic [31:0] addr);
        step(tag, 1'b1, OP_TRAP, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, addr);
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #2;
        compare_all("rst");
        check_val("rst_valid0", {31'd0, slot_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Boot edge, then three sequential advances.
        seq("boot");
        check_val("t1_pc0", pc, 32'h0);
        seq("t1a");
        check_val("t1_pc4", pc, 32'h4);
        seq("t1b");
        check_val("t1_pc8", pc, 32'h8);
        seq("t1c");
        check_val("t1_pcc", pc, 32'hC);
        check_val("t1_npc", npc, 32'h10);

        // Taken branch, no annul: delay slot runs, then target.
        trap_to("t2t", 32'h100);
        step("t2b", 1'b1, OP_BICC, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'd0);
        check_val("t2_pc", pc, 32'h104);
        check_val("t2_valid", {31'd0, slot_valid}, 32'd1);
        seq("t2s");
        check_val("t2_tgt", pc, 32'h140);

        // Not-taken with annul: delay slot squashed.
        trap_to("t3t", 32'h100);
        step("t3b", 1'b1, OP_BICC, 1'b0, 1'b0, 1'b1, 32'h40, 32'd0, 32'd0);
        check_val("t3_pc", pc, 32'h104);
        check_val("t3_valid", {31'd0, slot_valid}, 32'd0);
        seq("t3s");
        check_val("t3_pc2", pc, 32'h108);
        check_val("t3_valid2", {31'd0, slot_valid}, 32'd1);

        // ba,a backwards: squashed slot then target.
        trap_to("t4t", 32'h100);
        step("t4b", 1'b1, OP_BICC, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0, 32'd0);
        check_val("t4_pc", pc, 32'h104);
        check_val("t4_valid", {31'd0, slot_valid}, 32'd0);
        seq("t4s");
        check_val("t4_tgt", pc, 32'hF8);

        // Trap from 0x200.
        trap_to("t5a", 32'h200);
        trap_to("t5b", 32'h800);
        check_val("t5_pc", pc, 32'h800);
        check_val("t5_npc", npc, 32'h804);
        check_val("t5_valid", {31'd0, slot_valid}, 32'd1);

        // No advance: hold.
        step("hold", 1'b0, OP_TRAP, 1'b1, 1'b1, 1'b1, 32'h40, 32'h44, 32'h900);
        check_val("hold_pc", pc, 32'h800);

        // Trap while squashed is ignored.
        step("sqt_b", 1'b1, OP_BICC, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0, 32'd0);
        trap_to("sqt", 32'h4000);
        check_val("sqt_pc", pc, 32'h808);

        // Wrap-around.
        trap_to("wrap_t", 32'hFFFF_FFFC);
        check_val("wrap_npc", npc, 32'h0);
        seq("wrap_s");
        check_val("wrap_pc", pc, 32'h0);

        // Misaligned JMPL target, then an aligned one.
        step("mis_j", 1'b1, OP_JMPL, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1002, 32'd0);
        check_val("mis_set", {31'd0, misalign}, {31'd0, ALIGN_EN});
        step("mis_k", 1'b1, OP_JMPL, 1'b0, 1'b0, 1'b0, 32'd0, 32'h2000, 32'd0);
        check_val("mis_clr", {31'd0, misalign}, 32'd0);

        // Async reset in the middle of a squash.
        trap_to("rs_t", 32'h300);
        step("rs_b", 1'b1, OP_BICC, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("rs_async");
        check_val("rs_pc", pc, RST_PC);
        @(negedge clk);
        reset = 1'b0;
        seq("rs_boot");

        // Random stimulus.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d, j, t;
            d = $urandom & 32'hFFFF_FFFC;
            j = $urandom;
            if ($urandom_range(0, 3) != 0) j[1:0] = 2'b00;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
            step("rnd", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 d, j, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
